// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch unit and the control decoder.
package riscv_pkg;

  typedef logic [1:0] fetchState_t;

  localparam fetchState_t FETCH = 2'd0;
  localparam fetchState_t EXEC  = 2'd1;
  localparam fetchState_t HALT  = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BNE  = 2'b01;
  localparam logic [1:0] BR_BEQ  = 2'b10;

  // Opcodes shared with the control decoder (instr[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC selection: branch/jump decision, target and alignment.
module next_pc_gen
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  branch,
  input  logic        jal,
  input  logic        zero,
  input  logic [31:0] immExt,
  output logic        takeTarget_c,
  output logic [31:0] nextPc_c,
  output logic        misalign_c
);

  assign takeTarget_c = jal
                      | ((branch == BR_BEQ) & zero)
                      | ((branch == BR_BNE) & ~zero);

  assign nextPc_c   = takeTarget_c ? (pc + immExt) : (pc + 32'd4);
  assign misalign_c = (nextPc_c[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: fetch, hold for execute, advance PC; halts on fault.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemRdata,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  input  logic [1:0]  branch,
  input  logic        jal,
  input  logic        zero,
  input  logic [31:0] immExt,
  input  logic        stall,
  output logic        fault,
  output logic [31:0] instret
);

  localparam int unsigned CW = $clog2(IMEM_TIMEOUT + 1);

  fetchState_t   state, stateNext;
  logic [CW-1:0] waitCnt, waitNext;
  logic [31:0]   pcNext, pcPlus4Next, instrNext, instretNext;
  logic          faultNext;

  logic          takeTarget_c;
  logic [31:0]   nextPc_c;
  logic          misalign_c;

  next_pc_gen u_nextPcGen (
    .pc           (pc),
    .branch       (branch),
    .jal          (jal),
    .zero         (zero),
    .immExt       (immExt),
    .takeTarget_c (takeTarget_c),
    .nextPc_c     (nextPc_c),
    .misalign_c   (misalign_c)
  );

  assign imemAddr = pc;

  // Next-state and next-register values
  always_comb begin
    stateNext   = state;
    waitNext    = waitCnt;
    pcNext      = pc;
    pcPlus4Next = pcPlus4;
    instrNext   = instr;
    instretNext = instret;
    faultNext   = fault;
    case (state)
      FETCH: begin
        if (imemValid) begin
          instrNext = imemRdata;
          stateNext = EXEC;
        end else if (waitCnt == CW'(IMEM_TIMEOUT - 1)) begin
          faultNext = 1'b1;
          stateNext = HALT;
        end else begin
          waitNext = waitCnt + CW'(1);
        end
      end
      EXEC: begin
        if (!stall) begin
          if (takeTarget_c && misalign_c) begin
            faultNext = 1'b1;
            stateNext = HALT;
          end else begin
            pcNext      = nextPc_c;
            pcPlus4Next = nextPc_c + 32'd4;
            instretNext = instret + 32'd1;
            waitNext    = '0;
            stateNext   = FETCH;
          end
        end
      end
      HALT:    stateNext = HALT;
      default: stateNext = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      waitCnt    <= '0;
      pc         <= RESET_PC;
      pcPlus4    <= RESET_PC + 32'd4;
      instr      <= NOP_INSTR;
      instret    <= '0;
      fault      <= 1'b0;
      imemReq    <= 1'b1;
      instrValid <= 1'b0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitNext;
      pc         <= pcNext;
      pcPlus4    <= pcPlus4Next;
      instr      <= instrNext;
      instret    <= instretNext;
      fault      <= faultNext;
      imemReq    <= (stateNext == FETCH);
      instrValid <= (stateNext == EXEC);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReq, imemValid, instrValid, jal, zero, stall, fault;
  logic [31:0] imemAddr, imemRdata, instr, pc, pcPlus4, immExt, instret;
  logic [1:0]  branch;

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 = waiting for instruction, 1 = executing, 2 = halted
  int          mPhase;
  int          mMisses;
  logic [31:0] mPc, mInstr, mInstret;
  logic        mFault;

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemValid  (imemValid),
    .imemRdata  (imemRdata),
    .instr      (instr),
    .instrValid (instrValid),
    .pc         (pc),
    .pcPlus4    (pcPlus4),
    .branch     (branch),
    .jal        (jal),
    .zero       (zero),
    .immExt     (immExt),
    .stall      (stall),
    .fault      (fault),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mPhase   = 0;
    mMisses  = 0;
    mPc      = RESET_PC;
    mInstr   = NOP;
    mInstret = 0;
    mFault   = 1'b0;
  endfunction

  function automatic void modelStep();
    logic        take;
    logic [31:0] target;
    if (mPhase == 0) begin
      if (imemValid) begin
        mInstr = imemRdata;
        mPhase = 1;
      end else begin
        mMisses++;
        if (mMisses >= TIMEOUT) begin
          mFault = 1'b1;
          mPhase = 2;
        end
      end
    end else if (mPhase == 1 && !stall) begin
      take   = jal || (branch == 2'b10 && zero) || (branch == 2'b01 && !zero);
      target = take ? mPc + immExt : mPc + 32'd4;
      if (take && target[1:0] != 2'b00) begin
        mFault = 1'b1;
        mPhase = 2;
      end else begin
        mPc      = target;
        mInstret = mInstret + 32'd1;
        mMisses  = 0;
        mPhase   = 0;
      end
    end
  endfunction

  task automatic checkAll();
    check("imemReq",    32'(imemReq),    32'(mPhase == 0));
    check("instrValid", 32'(instrValid), 32'(mPhase == 1));
    check("imemAddr",   imemAddr,        mPc);
    check("pc",         pc,              mPc);
    check("pcPlus4",    pcPlus4,         mPc + 32'd4);
    check("instr",      instr,           mInstr);
    check("instret",    instret,         mInstret);
    check("fault",      32'(fault),      32'(mFault));
  endtask

  // One clock: inputs already driven, update the model at the edge, compare after it
  task automatic step();
    @(posedge clk);
    if (reset) modelReset();
    else modelStep();
    #1;
    checkAll();
  endtask

  task automatic idle();
    imemValid = 1'b1;
    imemRdata = $urandom;
    branch    = 2'b00;
    jal       = 1'b0;
    zero      = 1'b0;
    immExt    = 32'h0;
    stall     = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] heldInstr;
    int          starve;

    reset = 1'b1;
    idle();
    modelReset();
    #1;
    checkAll();
    step();
    step();
    reset = 1'b0;
    check("rst_imemReq", 32'(imemReq), 32'd1);
    check("rst_imemAddr", imemAddr, RESET_PC);
    check("rst_instr", instr, NOP);

    // Straight-line execution
    for (int i = 0; i < 6; i++) begin
      idle();
      step();
    end
    check("seq_pc", pc, 32'd12);
    check("seq_instret", instret, 32'd3);

    // Branch taken backward and not taken from 0x20
    idle(); step();
    jal = 1'b1; immExt = 32'h14; step();
    check("jal_to_20", pc, 32'h20);
    idle(); step();
    branch = 2'b10; zero = 1'b1; immExt = 32'hFFFF_FFF0; step();
    check("beq_taken", pc, 32'h10);
    idle(); step();
    jal = 1'b1; immExt = 32'h10; step();
    idle(); step();
    branch = 2'b10; zero = 1'b0; immExt = 32'hFFFF_FFF0; step();
    check("beq_not_taken", pc, 32'h24);

    // Stall holds everything for 5 cycles
    idle(); heldInstr = imemRdata; step();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imemRdata = $urandom;
      step();
      check("stall_pc", pc, 32'h24);
      check("stall_instr", instr, heldInstr);
      check("stall_valid", 32'(instrValid), 32'd1);
    end
    stall = 1'b0; step();
    check("after_stall_pc", pc, 32'h28);

    // Memory answers on the last cycle before timeout
    idle(); imemValid = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    imemValid = 1'b1; step();
    check("late_valid_exec", 32'(instrValid), 32'd1);
    check("late_valid_nofault", 32'(fault), 32'd0);

    // Asynchronous reset while executing at 0x80
    jal = 1'b1; immExt = 32'h58; step();
    idle(); step();
    check("at_80", pc, 32'h80);
    reset = 1'b1;
    #1;
    modelReset();
    checkAll();
    check("async_rst_pc", pc, RESET_PC);
    check("async_rst_instret", instret, 32'd0);
    step();
    reset = 1'b0;

    // Misaligned jump at 0x40 halts with fault
    idle(); step();
    jal = 1'b1; immExt = 32'h40; step();
    idle(); step();
    jal = 1'b1; immExt = 32'h6; step();
    check("misalign_fault", 32'(fault), 32'd1);
    check("misalign_pc", pc, 32'h40);
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_noreq", 32'(imemReq), 32'd0);
    end
    doReset();

    // Full timeout
    idle(); imemValid = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) step();
    check("timeout_fault", 32'(fault), 32'd1);
    check("timeout_noreq", 32'(imemReq), 32'd0);
    step();
    doReset();

    // Randomized traffic
    starve = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0) || (mPhase == 2 && $urandom_range(0, 7) == 0);
      if (starve == 0 && $urandom_range(0, 199) == 0) starve = $urandom_range(14, 17);
      if (starve > 0) begin
        imemValid = 1'b0;
        starve--;
      end else begin
        imemValid = ($urandom_range(0, 9) < 7);
      end
      imemRdata = $urandom;
      branch    = 2'($urandom_range(0, 3));
      jal       = ($urandom_range(0, 9) == 0);
      zero      = 1'($urandom_range(0, 1));
      stall     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) immExt = $urandom;
      else begin
        immExt = $urandom & 32'h0000_01FC;
        if ($urandom_range(0, 1) == 1) immExt = -immExt;
      end
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
